// File: rtl/data_memory_pkg.sv
// Shared types and constants for the data memory side of the load/store path.
package data_memory_pkg;

    // Load bus controller states.
    typedef enum logic [2:0] {
        IDLE,
        CACHE_WAIT,
        BUS_REQ,
        BUS_WAIT,
        RESPOND,
        DRAIN
    } lbc_state_t;

    // Default watchdog limit, in BUS_WAIT cycles, for an external bus read.
    localparam int LBC_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/bus_timeout_counter.sv
// Watchdog counter for external bus accesses. Counts enabled cycles since the
// last clear and flags the cycle in which the count reaches TIMEOUT_CYCLES.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Count enabled cycles, saturating at the limit; clear has priority.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT_CNT)) begin
            count <= count + CNT_W'(1);
        end
    end

    // The enabled cycle that brings the count up to the limit is the expiry cycle.
    assign expired = enable && (count == LAST_CNT);

endmodule

// File: rtl/load_bus_controller.sv
// Memory-side front end of the load unit: routes cachable reads to the data
// cache and non-cachable reads over the external bus with a timeout watchdog,
// then returns one word with a single-cycle valid pulse.
module load_bus_controller
    import data_memory_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = LBC_DEFAULT_TIMEOUT
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            read_i,
    input  logic            cachable_i,
    input  logic [XLEN-1:0] address_i,
    output logic            idle_o,
    output logic            data_valid_o,
    output logic [XLEN-1:0] data_o,
    output logic            bus_error_o,
    output logic            cache_read_o,
    output logic [XLEN-1:0] cache_address_o,
    input  logic            cache_valid_i,
    input  logic [XLEN-1:0] cache_data_i,
    output logic            bus_req_o,
    output logic [XLEN-1:0] bus_address_o,
    input  logic            bus_ack_i,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    input  logic            bus_err_i
);

    lbc_state_t      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic            timeout_expired;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (state_q == BUS_REQ),
        .enable  (state_q == BUS_WAIT),
        .expired (timeout_expired)
    );

    // State, latched address, returned data and error flag registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; responses outside their wait state are simply ignored.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (read_i) begin
                    addr_d  = address_i;
                    state_d = cachable_i ? CACHE_WAIT : BUS_REQ;
                end
            end
            CACHE_WAIT: begin
                if (cache_valid_i) begin
                    data_d  = cache_data_i;
                    err_d   = 1'b0;
                    state_d = RESPOND;
                end
            end
            BUS_REQ: begin
                if (bus_ack_i) begin
                    if (bus_rvalid_i) begin
                        data_d  = bus_rdata_i;
                        err_d   = bus_err_i;
                        state_d = RESPOND;
                    end else begin
                        state_d = BUS_WAIT;
                    end
                end
            end
            BUS_WAIT: begin
                if (bus_rvalid_i) begin
                    data_d  = bus_rdata_i;
                    err_d   = bus_err_i;
                    state_d = RESPOND;
                end else if (timeout_expired) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!read_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign idle_o          = (state_q == IDLE);
    assign data_valid_o    = (state_q == RESPOND);
    assign bus_error_o     = (state_q == RESPOND) && err_q;
    assign data_o          = data_q;
    assign cache_read_o    = (state_q == CACHE_WAIT);
    assign cache_address_o = addr_q;
    assign bus_req_o       = (state_q == BUS_REQ);
    assign bus_address_o   = {addr_q[XLEN-1:2], 2'b00};

endmodule

// File: tb/tb_load_bus_controller.sv
// Self-checking bench for load_bus_controller: directed scenarios plus a
// randomized transaction loop checked against a transaction-level model.
module tb_load_bus_controller;

    localparam int T = 8;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        read_i, cachable_i;
    logic [31:0] address_i;
    logic        idle_o, data_valid_o, bus_error_o;
    logic [31:0] data_o;
    logic        cache_read_o, cache_valid_i;
    logic [31:0] cache_address_o, cache_data_i;
    logic        bus_req_o, bus_ack_i, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_address_o, bus_rdata_i;

    int n_compared = 0;
    int n_mismatched = 0;

    // Observations from the most recent transaction.
    int          obs_nvalid, obs_lat;
    logic [31:0] obs_data, obs_cache_addr, obs_bus_addr;
    logic        obs_err, obs_saw_cache, obs_saw_bus, obs_bad_idle;
    logic        obs_extra_req, obs_idle_before, obs_idle_after, obs_timeout;

    load_bus_controller #(.XLEN(32), .TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .read_i(read_i), .cachable_i(cachable_i),
        .address_i(address_i), .idle_o(idle_o), .data_valid_o(data_valid_o),
        .data_o(data_o), .bus_error_o(bus_error_o), .cache_read_o(cache_read_o),
        .cache_address_o(cache_address_o), .cache_valid_i(cache_valid_i),
        .cache_data_i(cache_data_i), .bus_req_o(bus_req_o), .bus_address_o(bus_address_o),
        .bus_ack_i(bus_ack_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .bus_err_i(bus_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_slave();
        cache_valid_i = 1'b0;
        cache_data_i  = $urandom;
        bus_ack_i     = 1'b0;
        bus_rvalid_i  = 1'b0;
        bus_rdata_i   = $urandom;
        bus_err_i     = 1'b0;
    endtask

    // Transaction-level expectation: which response arrives and how many
    // cycles after read_i is first sampled the valid pulse appears.
    function automatic void model(input logic cach, input int cdly, input int ackdly,
                                  input int rvdly, input logic [31:0] rdat, input logic berr,
                                  output logic [31:0] ed, output logic ee, output int elat);
        if (cach) begin
            ed = rdat; ee = 1'b0; elat = 2 + cdly;
        end else if (rvdly <= T) begin
            ed = rdat; ee = berr; elat = 2 + ackdly + rvdly;
        end else begin
            ed = 32'h0; ee = 1'b1; elat = 2 + ackdly + T;
        end
    endfunction

    // Drive one read and act as cache/bus slave; rvdly counts cycles after the
    // ack cycle (0 = rvalid together with ack); hold = extra DRAIN cycles with read_i high.
    task automatic do_read(input logic [31:0] addr, input logic cach, input int cdly,
                           input int ackdly, input int rvdly, input logic [31:0] rdat,
                           input logic berr, input int late_rv, input int hold);
        int cyc, ackcyc, reqcnt, cachecnt, vcyc;
        bit done;
        obs_nvalid = 0; obs_lat = -1; obs_data = 32'hx; obs_err = 1'bx;
        obs_saw_cache = 0; obs_saw_bus = 0; obs_cache_addr = 0; obs_bus_addr = 0;
        obs_bad_idle = 0; obs_extra_req = 0; obs_idle_after = 0; obs_timeout = 0;
        obs_idle_before = idle_o;
        clear_slave();
        read_i = 1'b1; cachable_i = cach; address_i = addr;
        step();
        cyc = 1; ackcyc = -1; reqcnt = 0; cachecnt = 0; vcyc = -1; done = 0;
        while (!done) begin
            if (vcyc >= 0 && cyc > vcyc && (cache_read_o || bus_req_o)) obs_extra_req = 1;
            if (vcyc >= 0 && cyc > vcyc && cyc <= vcyc + hold + 1 && idle_o) obs_bad_idle = 1;
            if (cache_read_o) begin obs_saw_cache = 1; obs_cache_addr = cache_address_o; end
            if (bus_req_o) begin obs_saw_bus = 1; obs_bus_addr = bus_address_o; end
            if (data_valid_o) begin
                obs_nvalid++;
                if (vcyc < 0) begin
                    vcyc = cyc; obs_lat = cyc; obs_data = data_o; obs_err = bus_error_o;
                end
            end
            if (vcyc >= 0 && cyc == vcyc + hold + 2) begin
                obs_idle_after = idle_o;
                done = 1;
            end else if (cyc >= 300) begin
                obs_timeout = 1;
                done = 1;
            end else begin
                clear_slave();
                if (cache_read_o) begin
                    if (cachecnt == cdly) begin cache_valid_i = 1'b1; cache_data_i = rdat; end
                    cachecnt++;
                end
                if (bus_req_o) begin
                    if (reqcnt == ackdly) begin
                        bus_ack_i = 1'b1; ackcyc = cyc;
                        if (rvdly == 0) begin bus_rvalid_i = 1'b1; bus_rdata_i = rdat; bus_err_i = berr; end
                    end
                    reqcnt++;
                end
                if (ackcyc >= 0 && rvdly > 0 && cyc == ackcyc + rvdly) begin
                    bus_rvalid_i = 1'b1; bus_rdata_i = rdat; bus_err_i = berr;
                end
                if (ackcyc >= 0 && late_rv > 0 && cyc == ackcyc + late_rv) begin
                    bus_rvalid_i = 1'b1; bus_rdata_i = ~rdat; bus_err_i = 1'b1;
                end
                read_i = (vcyc < 0) || (cyc - vcyc <= hold);
                step();
                cyc++;
            end
        end
        clear_slave();
        read_i = 1'b0;
        if (obs_timeout) begin
            n_compared++; n_mismatched++;
            $display("[TB] FAIL txn_budget no response within 300 cycles addr=%h", addr);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; read_i = 1'b0; cachable_i = 1'b0; address_i = 32'h0;
        clear_slave();
        step(); step();
        n_compared++; if (idle_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_idle got=%b exp=1", idle_o); end
        n_compared++; if ({data_valid_o, bus_error_o, cache_read_o, bus_req_o} !== 4'b0) begin n_mismatched++; $display("[TB] FAIL reset_ctrl got=%b exp=0000", {data_valid_o, bus_error_o, cache_read_o, bus_req_o}); end
        n_compared++; if (data_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_data got=%h exp=0", data_o); end
        n_compared++; if ({cache_address_o, bus_address_o} !== 64'h0) begin n_mismatched++; $display("[TB] FAIL reset_addr got=%h/%h exp=0/0", cache_address_o, bus_address_o); end
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic test_cache_read();
        logic [31:0] ed; logic ee; int elat;
        model(1'b1, 1, 0, 0, 32'hDEAD_BEEF, 1'b0, ed, ee, elat);
        do_read(32'h0000_1004, 1'b1, 1, 0, 0, 32'hDEAD_BEEF, 1'b0, 0, 0);
        n_compared++; if (obs_idle_before !== 1'b1) begin n_mismatched++; $display("[TB] FAIL cache_idle_before got=%b exp=1", obs_idle_before); end
        n_compared++; if (obs_cache_addr !== 32'h0000_1004) begin n_mismatched++; $display("[TB] FAIL cache_addr got=%h exp=00001004", obs_cache_addr); end
        n_compared++; if (obs_data !== ed || obs_err !== ee) begin n_mismatched++; $display("[TB] FAIL cache_data got=%h/%b exp=%h/%b", obs_data, obs_err, ed, ee); end
        n_compared++; if (obs_lat != elat || obs_nvalid != 1) begin n_mismatched++; $display("[TB] FAIL cache_latency got=%0d x%0d exp=%0d x1", obs_lat, obs_nvalid, elat); end
        n_compared++; if (obs_saw_bus !== 1'b0) begin n_mismatched++; $display("[TB] FAIL cache_no_bus got=%b exp=0", obs_saw_bus); end
        n_compared++; if (obs_idle_after !== 1'b1) begin n_mismatched++; $display("[TB] FAIL cache_idle_after got=%b exp=1", obs_idle_after); end
    endtask

    task automatic test_bus_read();
        logic [31:0] ed; logic ee; int elat;
        model(1'b0, 0, 2, 3, 32'h1234_5678, 1'b0, ed, ee, elat);
        do_read(32'h8000_0002, 1'b0, 0, 2, 3, 32'h1234_5678, 1'b0, 0, 0);
        n_compared++; if (obs_bus_addr !== 32'h8000_0000) begin n_mismatched++; $display("[TB] FAIL bus_addr got=%h exp=80000000", obs_bus_addr); end
        n_compared++; if (obs_data !== ed || obs_err !== ee) begin n_mismatched++; $display("[TB] FAIL bus_data got=%h/%b exp=%h/%b", obs_data, obs_err, ed, ee); end
        n_compared++; if (obs_lat != elat || obs_nvalid != 1) begin n_mismatched++; $display("[TB] FAIL bus_latency got=%0d x%0d exp=%0d x1", obs_lat, obs_nvalid, elat); end
        n_compared++; if (obs_saw_cache !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bus_no_cache got=%b exp=0", obs_saw_cache); end
    endtask

    task automatic test_bus_error();
        do_read(32'h9000_0010, 1'b0, 0, 1, 2, 32'hCAFE_0001, 1'b1, 0, 0);
        n_compared++; if (obs_data !== 32'hCAFE_0001 || obs_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bus_err got=%h/%b exp=cafe0001/1", obs_data, obs_err); end
    endtask

    task automatic test_timeout();
        logic [31:0] ed; logic ee; int elat;
        model(1'b0, 0, 1, 1000, 32'h5555_AAAA, 1'b0, ed, ee, elat);
        do_read(32'h8000_0100, 1'b0, 0, 1, 1000, 32'h5555_AAAA, 1'b0, 0, 0);
        n_compared++; if (obs_data !== 32'h0 || obs_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL timeout_resp got=%h/%b exp=0/1", obs_data, obs_err); end
        n_compared++; if (obs_lat != elat || obs_nvalid != 1) begin n_mismatched++; $display("[TB] FAIL timeout_latency got=%0d x%0d exp=%0d x1", obs_lat, obs_nvalid, elat); end
        n_compared++; if (obs_idle_after !== 1'b1) begin n_mismatched++; $display("[TB] FAIL timeout_idle got=%b exp=1", obs_idle_after); end
    endtask

    task automatic test_rvalid_at_timeout();
        do_read(32'h8000_0200, 1'b0, 0, 1, T, 32'h0BAD_F00D, 1'b0, 0, 0);
        n_compared++; if (obs_data !== 32'h0BAD_F00D || obs_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rvalid_wins got=%h/%b exp=0badf00d/0", obs_data, obs_err); end
        n_compared++; if (obs_lat != 3 + T) begin n_mismatched++; $display("[TB] FAIL rvalid_wins_lat got=%0d exp=%0d", obs_lat, 3 + T); end
    endtask

    task automatic test_ack_rvalid_same();
        do_read(32'h8000_0300, 1'b0, 0, 1, 0, 32'hA5A5_A5A5, 1'b0, 1, 0);
        n_compared++; if (obs_nvalid != 1) begin n_mismatched++; $display("[TB] FAIL same_cycle_count got=%0d exp=1", obs_nvalid); end
        n_compared++; if (obs_data !== 32'hA5A5_A5A5 || obs_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL same_cycle_data got=%h/%b exp=a5a5a5a5/0", obs_data, obs_err); end
        n_compared++; if (obs_lat != 3) begin n_mismatched++; $display("[TB] FAIL same_cycle_lat got=%0d exp=3", obs_lat); end
        n_compared++; if (data_o !== 32'hA5A5_A5A5) begin n_mismatched++; $display("[TB] FAIL late_rvalid_ignored got=%h exp=a5a5a5a5", data_o); end
    endtask

    task automatic test_back_to_back();
        do_read(32'h0000_2000, 1'b1, 0, 0, 0, 32'h1111_2222, 1'b0, 0, 3);
        n_compared++; if (obs_extra_req !== 1'b0 || obs_nvalid != 1) begin n_mismatched++; $display("[TB] FAIL hold_no_reissue got=%b x%0d exp=0 x1", obs_extra_req, obs_nvalid); end
        n_compared++; if (obs_bad_idle !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_idle_low got=%b exp=0", obs_bad_idle); end
        n_compared++; if (obs_idle_after !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hold_idle_after got=%b exp=1", obs_idle_after); end
    endtask

    task automatic test_reset_mid();
        bit saw_valid, idle_bad;
        clear_slave();
        read_i = 1'b1; cachable_i = 1'b0; address_i = 32'h8000_0400;
        step();
        bus_ack_i = 1'b1;
        step();
        bus_ack_i = 1'b0;
        step(); step();
        #2;
        rst_n_i = 1'b0; read_i = 1'b0;
        #1;
        n_compared++; if (idle_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_idle got=%b exp=1", idle_o); end
        n_compared++; if ({data_valid_o, bus_error_o, cache_read_o, bus_req_o} !== 4'b0 || data_o !== 32'h0 || bus_address_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL midreset_outputs got=%b/%h/%h exp=0000/0/0", {data_valid_o, bus_error_o, cache_read_o, bus_req_o}, data_o, bus_address_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        saw_valid = 0; idle_bad = 0;
        for (int i = 0; i < 5; i++) begin
            bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_0000; bus_err_i = 1'b1;
            cache_valid_i = 1'b1; bus_ack_i = 1'b1;
            step();
            if (data_valid_o) saw_valid = 1;
            if (!idle_o) idle_bad = 1;
        end
        clear_slave();
        n_compared++; if (saw_valid || idle_bad) begin n_mismatched++; $display("[TB] FAIL midreset_ignore got=valid%0d/notidle%0d exp=0/0", saw_valid, idle_bad); end
        n_compared++; if (data_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL midreset_data got=%h exp=0", data_o); end
    endtask

    task automatic test_random();
        logic [31:0] addr, rdat, ed; logic cach, berr, ee;
        int cdly, ackdly, rvdly, hold, elat;
        for (int n = 0; n < 24; n++) begin
            addr = $urandom; rdat = $urandom; cach = 1'($urandom_range(0, 1));
            berr = 1'($urandom_range(0, 1));
            cdly = $urandom_range(0, 3); ackdly = $urandom_range(1, 3);
            rvdly = $urandom_range(0, T + 4); hold = $urandom_range(0, 3);
            model(cach, cdly, ackdly, rvdly, rdat, berr, ed, ee, elat);
            do_read(addr, cach, cdly, ackdly, rvdly, rdat, berr, 0, hold);
            n_compared++; if (obs_data !== ed || obs_err !== ee) begin n_mismatched++; $display("[TB] FAIL rand%0d_data got=%h/%b exp=%h/%b", n, obs_data, obs_err, ed, ee); end
            n_compared++; if (obs_lat != elat || obs_nvalid != 1) begin n_mismatched++; $display("[TB] FAIL rand%0d_latency got=%0d x%0d exp=%0d x1", n, obs_lat, obs_nvalid, elat); end
            if (cach) begin
                n_compared++; if (obs_cache_addr !== addr || obs_saw_bus !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rand%0d_cache_addr got=%h/bus%b exp=%h/bus0", n, obs_cache_addr, obs_saw_bus, addr); end
            end else begin
                n_compared++; if (obs_bus_addr !== {addr[31:2], 2'b00} || obs_saw_cache !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rand%0d_bus_addr got=%h/cache%b exp=%h/cache0", n, obs_bus_addr, obs_saw_cache, {addr[31:2], 2'b00}); end
            end
            n_compared++; if (obs_bad_idle !== 1'b0 || obs_extra_req !== 1'b0 || obs_idle_after !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rand%0d_drain got=%b%b%b exp=001", n, obs_bad_idle, obs_extra_req, obs_idle_after); end
        end
    endtask

    initial begin
        test_reset();
        test_cache_read();
        test_bus_read();
        test_bus_error();
        test_timeout();
        test_rvalid_at_timeout();
        test_ack_rvalid_same();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
